asteroid_plotter: RTL and testbench
===================================

ASTEROID_PLOTTER -- requirements
Module: asteroid_plotter

Interface
REQ-001 Parameter SPRITE_W, default 4, sprite width in pixels (1..8).
REQ-002 Parameter SPRITE_H, default 4, sprite height in pixels (1..8).
REQ-003 Parameter BG_COLOUR, default 3'b000, erase colour.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to move sprite from old to new position.
REQ-007 old_x  in  8; old_y  in  7  top-left of sprite to erase.
REQ-008 new_x  in  8; new_y  in  7  top-left of sprite to draw.
REQ-009 colour_in  in  3  sprite colour.
REQ-010 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-011 done  out  1  one-cycle pulse at end of request.
REQ-012 vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1  pixel-write port to VGA adapter.

Function
REQ-013 FSM states IDLE, ERASE, DRAW, DONE; IDLE->ERASE on start, ERASE->DRAW after last pixel, DRAW->DONE after last pixel, DONE->IDLE unconditionally.
REQ-014 start accepted only in IDLE; old/new coordinates and colour_in registered on acceptance; start while busy ignored with no side effect.
REQ-015 ERASE and DRAW each visit SPRITE_W*SPRITE_H pixels, one per cycle, raster order (column inner, row outer).
REQ-016 Pixel (r,c) address = base_x+c, base_y+r, computed 9-bit/8-bit wide, no wrap.
REQ-017 vga_plot high only when address x<160 and y<120; off-screen pixels still consume their cycle with vga_plot=0.
REQ-018 ERASE drives vga_colour=BG_COLOUR at old position; DRAW drives latched colour at new position.
REQ-019 Latency: start at cycle 0, first ERASE pixel cycle 1, first DRAW pixel cycle 1+N, done at cycle 1+2N (N=SPRITE_W*SPRITE_H; 33 for defaults).
REQ-020 Outputs registered; vga_x/vga_y/vga_colour hold last value when vga_plot=0.
REQ-021 start in DONE cycle ignored; earliest re-acceptance is following IDLE cycle.

Reset
REQ-022 reset forces IDLE, counters 0, busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0 on next edge.
REQ-023 reset mid-ERASE/DRAW aborts request with no done pulse; reset dominates simultaneous start.

Configuration
REQ-024 Macro PLOT_SPRITE_MASK_EN: when defined, defaults only, a 16-bit mask 16'h6FF6 (bit index r*4+c) gates vga_plot; masked pixels consume cycle with vga_plot=0, in both ERASE and DRAW.
REQ-025 Without PLOT_SPRITE_MASK_EN, full rectangle plotted; cycle timing identical in both builds.

Structure
REQ-026 Shared package asteroid_pkg holds SCREEN_W=160, SCREEN_H=120, colour typedef (3-bit), plotter state enum, sprite mask constant.
REQ-027 One sub-module sprite_pixel_counter: row/column counter with clear, enable and last-pixel flag; instanced once.

Verification
REQ-028 old=(10,20), new=(11,20), colour 3'b111, start -> 16 plots colour 0 over x10..13,y20..23, then 16 plots colour 7 over x11..14,y20..23, done at cycle 33.
REQ-029 new=(158,118) -> only pixels x158..159, y118..119 plotted in DRAW (4 plots), other 12 cycles vga_plot=0, done still at cycle 33.
REQ-030 start pulsed at cycles 0 and 5 -> one request only, single done at 33; start at 34 accepted.
REQ-031 reset asserted at cycle 10 -> next cycle busy=0, vga_plot=0, no done; fresh start completes normally.
REQ-032 PLOT_SPRITE_MASK_EN defined, new=(40,40) -> DRAW plots 12 pixels, corners (40,40),(43,40),(40,43),(43,43) skipped, done at cycle 33.

Source files
------------

// File: rtl/asteroid_pkg.sv
// Shared screen geometry, colour type, plotter state encoding and sprite mask
// for the asteroid sprite plotter.
package asteroid_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } plot_state_e;

  // Bit index is row*4 + col; the four zero bits are the 4x4 sprite corners.
  localparam logic [15:0] SPRITE_MASK = 16'h6FF6;

endpackage

// File: rtl/sprite_pixel_counter.sv
// Raster-order row/column counter for one sprite pass.
// The column is the inner count and the row is the outer count.
module sprite_pixel_counter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  localparam logic [2:0] COL_MAX = 3'(SPRITE_W - 1);
  localparam logic [2:0] ROW_MAX = 3'(SPRITE_H - 1);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Wrapping on the last pixel leaves the counter at zero for the next pass.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear || (en && last)) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs and process ordering cannot matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/asteroid_plotter.sv
// Moves a sprite: erases it at the old position, then redraws it at the new one
// through a registered VGA pixel-write port. Define PLOT_SPRITE_MASK_EN to
// gate pixel writes with the 4x4 corner mask.
module asteroid_plotter
  import asteroid_pkg::*;
#(
  parameter int      SPRITE_W  = 4,
  parameter int      SPRITE_H  = 4,
  parameter colour_t BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] old_x,
  input  logic [6:0] old_y,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  plot_state_e state_q, state_d;

  logic [7:0] old_x_q, old_x_d, new_x_q, new_x_d;
  logic [6:0] old_y_q, old_y_d, new_y_q, new_y_d;
  colour_t    colour_q, colour_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       plot_q, plot_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  colour_t    vga_colour_q, vga_colour_d;

  logic [2:0] row, col;
  logic       last_pixel;
  logic       cnt_clear, cnt_en;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       on_screen;
  logic       mask_ok;

  assign cnt_clear = (state_q == ST_IDLE);
  assign cnt_en    = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  sprite_pixel_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_pixel_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .row   (row),
    .col   (col),
    .last  (last_pixel)
  );

  // State register. NOTE: reset is synchronous, so it is tested inside the
  // clocked block rather than listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)      state_d = ST_ERASE;
      ST_ERASE: if (last_pixel) state_d = ST_DRAW;
      ST_DRAW:  if (last_pixel) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Pixel address is widened so sprites hanging off the right or bottom edge
  // are detected rather than wrapping back onto the screen.
  assign base_x    = (state_q == ST_ERASE) ? old_x_q : new_x_q;
  assign base_y    = (state_q == ST_ERASE) ? old_y_q : new_y_q;
  assign pix_x     = {1'b0, base_x} + {6'd0, col};
  assign pix_y     = {1'b0, base_y} + {5'd0, row};
  assign on_screen = (pix_x < 9'(SCREEN_W)) && (pix_y < 8'(SCREEN_H));

`ifdef PLOT_SPRITE_MASK_EN
  assign mask_ok = SPRITE_MASK[{row[1:0], col[1:0]}];
`else
  assign mask_ok = 1'b1;
`endif

  // Output logic. NOTE: every signal gets a default first so no path through
  // the block leaves a value unassigned and infers a latch.
  always_comb begin
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    colour_d     = colour_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    busy_d       = (state_q != ST_IDLE);
    done_d       = (state_q == ST_DONE);
    plot_d       = cnt_en && on_screen && mask_ok;

    if (state_q == ST_IDLE && start) begin
      old_x_d  = old_x;
      old_y_d  = old_y;
      new_x_d  = new_x;
      new_y_d  = new_y;
      colour_d = colour_in;
    end

    if (plot_d) begin
      vga_x_d      = pix_x[7:0];
      vga_y_d      = pix_y[6:0];
      vga_colour_d = (state_q == ST_ERASE) ? BG_COLOUR : colour_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      old_x_q      <= '0;
      old_y_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      colour_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      colour_q     <= colour_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_asteroid_plotter.sv
// Self-checking bench for asteroid_plotter: directed scenarios plus random
// requests, compared cycle by cycle against a behavioural pixel-list model.
module tb_asteroid_plotter;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int BG = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] old_x, new_x;
  logic [6:0] old_y, new_y;
  logic [2:0] colour_in;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int vectors     = 0;
  int miscompares = 0;

  // Model's view of the last pixel actually written (held outputs).
  logic [7:0] hx;
  logic [6:0] hy;
  logic [2:0] hc;

  asteroid_plotter #(
    .SPRITE_W  (W),
    .SPRITE_H  (H),
    .BG_COLOUR (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .old_x      (old_x),
    .old_y      (old_y),
    .new_x      (new_x),
    .new_y      (new_y),
    .colour_in  (colour_in),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [20:0] expv);
    logic [20:0] obs;
    obs = {busy, done, vga_plot, vga_x, vga_y, vga_colour};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed busy/done/plot/x/y/c=%0b/%0b/%0b/%0d/%0d/%0d expected %0b/%0b/%0b/%0d/%0d/%0d",
             tag, cyc, obs[20], obs[19], obs[18], obs[17:10], obs[9:3], obs[2:0],
             expv[20], expv[19], expv[18], expv[17:10], expv[9:3], expv[2:0]);
    end
  endtask

  function automatic logic [20:0] idle_vec();
    return {3'b000, hx, hy, hc};
  endfunction

  // Expected outputs k cycles after the start was sampled (k = 1 .. 2N+1):
  // N erase pixels, N draw pixels, then the done cycle.
  function automatic logic [20:0] model(input int k, input int ox, input int oy,
                                        input int nx, input int ny, input int col);
    bit is_draw, plot, is_done;
    int i, r, c, x, y;
    is_done = (k == 2 * N + 1);
    plot    = 1'b0;
    if (!is_done) begin
      is_draw = (k > N);
      i       = is_draw ? k - 1 - N : k - 1;
      r       = i / W;
      c       = i % W;
      x       = (is_draw ? nx : ox) + c;
      y       = (is_draw ? ny : oy) + r;
      plot    = (x < 160) && (y < 120);
`ifdef PLOT_SPRITE_MASK_EN
      if ((r == 0 || r == H - 1) && (c == 0 || c == W - 1)) plot = 1'b0;
`endif
      if (plot) begin
        hx = 8'(x);
        hy = 7'(y);
        hc = is_draw ? 3'(col) : 3'(BG);
      end
    end
    return {1'b1, is_done, plot, hx, hy, hc};
  endfunction

  // Issues one request and checks every cycle through done. glitch re-pulses
  // start (with different data) at cycle 5; abort_at asserts reset so it is
  // sampled on that cycle's edge.
  task automatic run_req(input string tag, input int ox, input int oy, input int nx,
                         input int ny, input int col, input bit glitch, input int abort_at);
    bit aborted;
    aborted   = 1'b0;
    old_x     = 8'(ox);
    old_y     = 7'(oy);
    new_x     = 8'(nx);
    new_y     = 7'(ny);
    colour_in = 3'(col);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 2 * N + 1; k++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && k == abort_at) begin
        aborted = 1'b1;
        reset   = 1'b0;
        hx = '0;
        hy = '0;
        hc = '0;
      end
      if (aborted) check(tag, k, idle_vec());
      else         check(tag, k, model(k, ox, oy, nx, ny, col));
      if (abort_at != 0 && k == abort_at - 1) reset = 1'b1;
      if (glitch && k == 4) begin
        start     = 1'b1;
        new_x     = 8'd0;
        new_y     = 7'd0;
        colour_in = 3'b010;
      end
      if (glitch && k == 5) start = 1'b0;
    end
  endtask

  initial begin
    int ox, oy, nx, ny;
    reset     = 1'b1;
    start     = 1'b0;
    old_x     = '0;
    old_y     = '0;
    new_x     = '0;
    new_y     = '0;
    colour_in = '0;
    hx = '0;
    hy = '0;
    hc = '0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", 0, idle_vec());
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("reset_beats_start", 1, idle_vec());

    run_req("move_right", 10, 20, 11, 20, 7, 1'b0, 0);
    run_req("start_while_busy", 30, 30, 50, 50, 5, 1'b1, 0);
    run_req("back_to_back", 50, 50, 60, 60, 2, 1'b0, 0);
    run_req("bottom_right_clip", 0, 0, 158, 118, 3, 1'b0, 0);
    run_req("mask_probe", 36, 36, 40, 40, 6, 1'b0, 0);
    run_req("reset_abort", 20, 20, 21, 21, 6, 1'b0, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("post_abort_idle", 0, idle_vec());
    end
    run_req("after_abort", 100, 100, 101, 99, 4, 1'b0, 0);

    for (int t = 0; t < 10; t++) begin
      ox = (t % 2 == 0) ? int'($urandom_range(150, 170)) : int'($urandom_range(0, 255));
      oy = (t % 2 == 0) ? int'($urandom_range(112, 127)) : int'($urandom_range(0, 127));
      nx = int'($urandom_range(0, 255));
      ny = int'($urandom_range(0, 127));
      run_req("random", ox, oy, nx, ny, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
